// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
//   glyph_t     - 6-bit glyph code
//   SEG_TABLE   - 64-entry code -> {dp,g,f,e,d,c,b,a} segment map
//   SEG_BLANK   - all segments off
//   SEG_DP_ONLY - decimal point only (unassigned codes 42..63)
package seg7_pkg;

  typedef logic [5:0] glyph_t;

  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP_ONLY = 8'h80;

  // 0-15 hex digits, 16-41 alphanumeric set, everything else dp only.
  localparam logic [7:0] SEG_TABLE [64] = '{
     0: 8'h3F,  1: 8'h06,  2: 8'h5B,  3: 8'h4F,
     4: 8'h66,  5: 8'h6D,  6: 8'h7D,  7: 8'h07,
     8: 8'h7F,  9: 8'h6F, 10: 8'h77, 11: 8'h7C,
    12: 8'h39, 13: 8'h5E, 14: 8'h79, 15: 8'h71,
    16: 8'h77,  // A
    17: 8'h7C,  // b
    18: 8'h39,  // C
    19: 8'h58,  // c
    20: 8'h5E,  // d
    21: 8'h79,  // E
    22: 8'h71,  // F
    23: 8'h6F,  // g
    24: 8'h76,  // H
    25: 8'h74,  // h
    26: 8'h10,  // i
    27: 8'h30,  // I
    28: 8'h1E,  // J
    29: 8'h38,  // L
    30: 8'h54,  // n
    31: 8'h3F,  // O
    32: 8'h5C,  // o
    33: 8'h73,  // P
    34: 8'h67,  // q
    35: 8'h50,  // r
    36: 8'h6D,  // S
    37: 8'h78,  // t
    38: 8'h3E,  // U
    39: 8'h1C,  // u
    40: 8'h6E,  // y
    41: 8'h63,  // upper o (degree-style)
    default: SEG_DP_ONLY
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational glyph code -> segment pattern lookup.
//   code - glyph code (glyph_t)
//   seg  - {dp,g,f,e,d,c,b,a}, active-high
import seg7_pkg::*;

module seg7_glyph_decode (
  input  glyph_t     code,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[code];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment display scanner with a
// double-buffered code load (pending -> active swap only at frame end).
//   clk_2      - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - capture codes when ready
//   codes      - 6 bits per digit, digit i at [6i+5:6i]
//   blink_mask - per-digit blink enable (only with SEG7_BLINK_EN)
//   ready      - pending buffer empty
//   SEG        - registered segments {dp,g,f,e,d,c,b,a}
//   DIG        - registered one-hot digit enable
// Optional feature macro: SEG7_BLINK_EN (blink_mask port + frame-count blink).
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int NDIGITS      = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                   clk_2,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [6*NDIGITS-1:0]   codes,
`ifdef SEG7_BLINK_EN
  input  logic [NDIGITS-1:0]     blink_mask,
`endif
  output logic                   ready,
  output logic [7:0]             SEG,
  output logic [NDIGITS-1:0]     DIG
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [CW-1:0]            div_cnt;
  logic [DW-1:0]            dix;
  glyph_t [NDIGITS-1:0]     active;
  glyph_t [NDIGITS-1:0]     pending;
  logic                     pend_vld;
  logic                     slot_end, frame_end, blank_dig;
  logic [7:0]               seg_dec;

  assign slot_end  = (div_cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (dix == DW'(NDIGITS - 1));
  assign ready     = !pend_vld;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dix     <= '0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end)
        dix <= (dix == DW'(NDIGITS - 1)) ? '0 : dix + 1'b1;
    end
  end

  // Promotion wins over capture: while pending is full ready is low, so a
  // load can never collide with the swap. A load in a frame-end cycle with
  // an empty buffer is captured and waits for the next frame end.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      active   <= {NDIGITS{6'd63}};
      pending  <= '0;
      pend_vld <= 1'b0;
    end else if (frame_end && pend_vld) begin
      active   <= pending;
      pend_vld <= 1'b0;
    end else if (load && !pend_vld) begin
      pending  <= codes;
      pend_vld <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] frm_cnt;
  logic          phase;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (frame_end) begin
      if (frm_cnt == BW'(BLINK_FRAMES - 1)) begin
        frm_cnt <= '0;
        phase   <= ~phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign blank_dig = phase && blink_mask[dix];
`else
  assign blank_dig = 1'b0;
`endif

  seg7_glyph_decode u_dec (
    .code (active[dix]),
    .seg  (seg_dec)
  );

  // Leading guard cycles keep segments dark while DIG switches (ghosting).
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      SEG <= SEG_BLANK;
      DIG <= '0;
    end else begin
      SEG <= ((div_cnt < CW'(GUARD)) || blank_dig) ? SEG_BLANK : seg_dec;
      DIG <= NDIGITS'(1) << dix;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FR = N * S;

  logic           clk_2 = 1'b0;
  logic           rst_n = 1'b0;
  logic           load  = 1'b0;
  logic [6*N-1:0] codes = '0;
  logic [N-1:0]   bmask = '0;
  logic           ready;
  logic [7:0]     SEG;
  logic [N-1:0]   DIG;

  seg7_scan_driver #(.NDIGITS(N), .SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk_2      (clk_2),
    .rst_n      (rst_n),
    .load       (load),
    .codes      (codes),
`ifdef SEG7_BLINK_EN
    .blink_mask (bmask),
`endif
    .ready      (ready),
    .SEG        (SEG),
    .DIG        (DIG)
  );

  always #5 clk_2 = ~clk_2;

  int errors = 0;
  int checks = 0;

  // reference model state
  int c;                 // cycles since reset release
  int mact [N];
  int mpend[N];
  bit mpv;
  int cur_d, cur_off;

  typedef struct {
    logic [6*N-1:0]  codes;
    logic [N-1:0][7:0] exp;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [7:0] glyph(input int code);
    case (code)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F; 10: return 8'h77; 11: return 8'h7C;
     12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; 15: return 8'h71;
     16: return 8'h77; 17: return 8'h7C; 18: return 8'h39; 19: return 8'h58;
     20: return 8'h5E; 21: return 8'h79; 22: return 8'h71; 23: return 8'h6F;
     24: return 8'h76; 25: return 8'h74; 26: return 8'h10; 27: return 8'h30;
     28: return 8'h1E; 29: return 8'h38; 30: return 8'h54; 31: return 8'h3F;
     32: return 8'h5C; 33: return 8'h73; 34: return 8'h67; 35: return 8'h50;
     36: return 8'h6D; 37: return 8'h78; 38: return 8'h3E; 39: return 8'h1C;
     40: return 8'h6E; 41: return 8'h63;
      default: return 8'h80;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0;
    mpv = 0;
    for (int i = 0; i < N; i++) mact[i] = 63;
  endtask

  // One clock: predict from the pre-edge inputs, advance, compare.
  task automatic cycle();
    int pos, d, off, ph;
    logic [7:0] es;
    pos = c % FR;
    d   = pos / S;
    off = pos % S;
    ph  = (c / FR / BF) % 2;
    es  = (off < G) ? 8'h00 : glyph(mact[d]);
`ifdef SEG7_BLINK_EN
    if (ph == 1 && bmask[d]) es = 8'h00;
`endif
    if (pos == FR - 1 && mpv) begin
      for (int i = 0; i < N; i++) mact[i] = mpend[i];
      mpv = 0;
    end else if (load && !mpv) begin
      for (int i = 0; i < N; i++) mpend[i] = int'(codes[6*i +: 6]);
      mpv = 1;
    end
    @(posedge clk_2); #1;
    check("dig", 32'(DIG), 32'(1 << d));
    check("seg", 32'(SEG), 32'(es));
    check("ready", 32'(ready), 32'(!mpv));
    cur_d = d; cur_off = off;
    c++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin cycle(); n++; end
    check("ready_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    int seen77, n;
    vecs[0].codes = {6'd3, 6'd2, 6'd1, 6'd0};    vecs[0].exp = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    vecs[1].codes = {6'd50, 6'd41, 6'd16, 6'd15}; vecs[1].exp = {8'h80, 8'h63, 8'h77, 8'h71};
    vecs[2].codes = {6'd63, 6'd42, 6'd10, 6'd28}; vecs[2].exp = {8'h80, 8'h80, 8'h77, 8'h1E};
    vecs[3].codes = {6'd20, 6'd24, 6'd35, 6'd11}; vecs[3].exp = {8'h5E, 8'h76, 8'h50, 8'h7C};

    // reset state
    model_reset();
    repeat (2) @(negedge clk_2);
    check("rst_seg", 32'(SEG), 32'h00);
    check("rst_dig", 32'(DIG), 32'h0);
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;

    // idle scan: dp-only with guard blank
    repeat (FR + 3) cycle();

    // table vectors
    for (int v = 0; v < 4; v++) begin
      wait_ready();
      repeat ($urandom_range(0, FR - 1)) cycle();
      load = 1'b1; codes = vecs[v].codes;
      cycle();
      check("ready_drop", 32'(ready), 32'd0);
      seen77 = 0;
      if (v == 0) codes = {N{6'd10}};  // must be ignored while not ready
      else load = 1'b0;
      n = 0;
      while (!ready && n < 100) begin
        cycle(); n++;
        if (SEG == 8'h77) seen77++;
      end
      load = 1'b0;
      check("promote_timeout", 32'(ready), 32'd1);
      for (int k = 0; k < FR; k++) begin
        cycle();
        if (SEG == 8'h77) seen77++;
        if (cur_off >= G) check($sformatf("vec%0d_d%0d", v, cur_d), 32'(SEG), 32'(vecs[v].exp[cur_d]));
      end
      if (v == 0) check("ignored_load_77", seen77, 0);
    end

    // load exactly in the frame-end cycle
    wait_ready();
    while ((c % FR) != FR - 1) cycle();
    load = 1'b1; codes = {6'd7, 6'd8, 6'd9, 6'd4};
    cycle();
    load = 1'b0;
    repeat (2 * FR) cycle();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      load  = ($urandom_range(0, 3) == 0);
      codes = 24'($urandom);
`ifdef SEG7_BLINK_EN
      if ($urandom_range(0, 40) == 0) bmask = 4'($urandom);
`endif
      cycle();
    end
    load = 1'b0;
    bmask = '0;

    // async reset mid-slot with pending valid
    wait_ready();
    repeat (5) cycle();
    load = 1'b1; codes = {6'd1, 6'd1, 6'd1, 6'd1};
    cycle();
    load = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(SEG), 32'h00);
    check("arst_dig", 32'(DIG), 32'h0);
    check("arst_ready", 32'(ready), 32'd1);
    model_reset();
    @(negedge clk_2);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FR; k++) begin
      cycle();
      if (cur_off >= G) check("post_rst_dp", 32'(SEG), 32'h80);
    end

`ifdef SEG7_BLINK_EN
    // blink digit 1 only, from a clean frame origin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk_2);
    rst_n = 1'b1;
    load = 1'b1; codes = {6'd3, 6'd2, 6'd1, 6'd0};
    cycle();
    load = 1'b0;
    bmask = 4'b0010;
    repeat (8 * FR) cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
